// File: rtl/data_mem_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_mem_seq : DEPTH x DATA_W data memory, combinational read, clocked     |
// |                write, self-sequenced zero sweep + preload table at reset.  |
// | Optional feature macro: DATA_MEM_PARITY_EN (per-word even parity bit).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module data_mem_seq #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 8,
  parameter int DEPTH         = 256,
  parameter int TAP_BASE      = 130,
  parameter int CLEAR_ON_INIT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WriteEn,
  input  logic [ADDR_W-1:0] DataAddress,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Ready,
  output logic              WriteDropped
`ifdef DATA_MEM_PARITY_EN
  ,
  output logic              ParityErr
`endif
);

  localparam int c_CNT_W = ADDR_W + 1;
  localparam int c_TAP_N = 11;
`ifdef DATA_MEM_PARITY_EN
  localparam int c_MEM_W = DATA_W + 1;
`else
  localparam int c_MEM_W = DATA_W;
`endif
  localparam logic [c_CNT_W-1:0] c_DEPTH_X  = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_LAST_WRD = c_CNT_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_LAST_TAP = c_CNT_W'(c_TAP_N - 1);

  typedef enum logic [1:0] {
    RST     = 2'd0,
    CLEAR   = 2'd1,
    PRELOAD = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nx;
  logic                 r_drop;
  logic                 w_drop_nx;

  logic                 w_we;
  logic [ADDR_W-1:0]    w_waddr;
  logic [DATA_W-1:0]    w_wdata;
  logic [c_MEM_W-1:0]   w_wword;
  logic [c_MEM_W-1:0]   w_rword;
  logic                 w_addr_ok;

  logic [3:0]           w_tap_idx;
  logic [3:0]           w_tap_off;
  logic [31:0]          w_tap_tgt;
  logic                 w_tap_hit;

  logic [c_MEM_W-1:0]   r_mem [DEPTH];

  function automatic logic [7:0] tap_data(input logic [3:0] idx);
    logic [7:0] d;
    case (idx)
      4'd0:    d = 8'h60;
      4'd1:    d = 8'h48;
      4'd2:    d = 8'h78;
      4'd3:    d = 8'h72;
      4'd4:    d = 8'h6A;
      4'd5:    d = 8'h69;
      4'd6:    d = 8'h5C;
      4'd7:    d = 8'h7E;
      4'd8:    d = 8'h7B;
      4'd9:    d = 8'h20;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  // Table offsets skip 9: entries 9 and 10 land at offsets 10 and 11.
  assign w_tap_idx = r_cnt[3:0];
  assign w_tap_off = (w_tap_idx > 4'd8) ? (w_tap_idx + 4'd1) : w_tap_idx;
  assign w_tap_tgt = 32'(TAP_BASE) + {28'd0, w_tap_off};
  assign w_tap_hit = (w_tap_tgt < 32'(DEPTH));

  assign w_addr_ok = ({1'b0, DataAddress} < c_DEPTH_X);
  assign Ready     = (r_state == RUN);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_we       = 1'b0;
    w_waddr    = '0;
    w_wdata    = '0;
    case (r_state)
      RST: begin
        w_cnt_nx   = '0;
        w_state_nx = (CLEAR_ON_INIT != 0) ? CLEAR : PRELOAD;
      end
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cnt[ADDR_W-1:0];
        if (r_cnt == c_LAST_WRD) begin
          w_cnt_nx   = '0;
          w_state_nx = PRELOAD;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      PRELOAD: begin
        w_we    = w_tap_hit;
        w_waddr = w_tap_tgt[ADDR_W-1:0];
        w_wdata = DATA_W'(tap_data(w_tap_idx));
        if (r_cnt == c_LAST_TAP) begin
          w_cnt_nx   = '0;
          w_state_nx = RUN;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      RUN: begin
        w_we    = WriteEn && w_addr_ok;
        w_waddr = DataAddress;
        w_wdata = DataIn;
      end
      default: begin
        w_state_nx = RST;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Any core write the port cannot accept (init still running or address
  // beyond DEPTH) is flagged for one cycle.
  assign w_drop_nx = WriteEn && !(Ready && w_addr_ok);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= RST;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_drop  <= w_drop_nx;
    end
  end

  assign WriteDropped = r_drop;

`ifdef DATA_MEM_PARITY_EN
  assign w_wword = {^w_wdata, w_wdata};
`else
  assign w_wword = w_wdata;
`endif

  // Array has no reset: contents survive Reset and are rebuilt by the init walk.
  always_ff @(posedge Clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wword;
    end
  end

  assign w_rword = r_mem[DataAddress];
  assign DataOut = (Ready && w_addr_ok) ? w_rword[DATA_W-1:0] : '0;

`ifdef DATA_MEM_PARITY_EN
  assign ParityErr = Ready && w_addr_ok && (w_rword[DATA_W] != ^w_rword[DATA_W-1:0]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_mem_seq : bench for data_mem_seq, default instance plus a          |
// |                   DEPTH=136 no-sweep instance, checked against a model.    |
// | Revision: 1.1                                                              |
// +----------------------------------------------------------------------------+
module tb_data_mem_seq;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       rst1, we1, rdy1, wd1;
    logic [7:0] addr1, din1, dout1;
    logic       rst2, we2, rdy2, wd2;
    logic [7:0] addr2, din2, dout2;
`ifdef DATA_MEM_PARITY_EN
    logic       perr1, perr2;
`endif

    data_mem_seq u_dut (
        .Clk(Clk), .Reset(rst1), .WriteEn(we1), .DataAddress(addr1), .DataIn(din1),
        .DataOut(dout1), .Ready(rdy1), .WriteDropped(wd1)
`ifdef DATA_MEM_PARITY_EN
        , .ParityErr(perr1)
`endif
    );

    data_mem_seq #(.DEPTH(136), .CLEAR_ON_INIT(0)) u_dut2 (
        .Clk(Clk), .Reset(rst2), .WriteEn(we2), .DataAddress(addr2), .DataIn(din2),
        .DataOut(dout2), .Ready(rdy2), .WriteDropped(wd2)
`ifdef DATA_MEM_PARITY_EN
        , .ParityErr(perr2)
`endif
    );

    int errors = 0;
    int checks = 0;

    int         offs [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 11};
    logic [7:0] vals [11] = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69,
                              8'h5C, 8'h7E, 8'h7B, 8'h20, 8'h00};

    logic [7:0] model1 [256];
    logic [7:0] model2 [256];
    bit         known2 [256];

    task automatic init_model1();
        for (int a = 0; a < 256; a++) model1[a] = 8'h00;
        for (int i = 0; i < 11; i++)
            if (130 + offs[i] < 256) model1[130 + offs[i]] = vals[i];
    endtask

    task automatic init_model2();
        for (int i = 0; i < 11; i++)
            if (130 + offs[i] < 136) begin
                model2[130 + offs[i]] = vals[i];
                known2[130 + offs[i]] = 1'b1;
            end
    endtask

    task automatic wait_ready1(input int expected);
        int n = 0;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (!rdy1 && n < 600);
        checks++;
        if (rdy1 !== 1'b1 || n != expected) begin
            errors++;
            $display("FAIL init_latency1: ready=%b after %0d edges, required 1 after %0d", rdy1, n, expected);
        end
    endtask

    task automatic wait_ready2(input int expected);
        int n = 0;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (!rdy2 && n < 600);
        checks++;
        if (rdy2 !== 1'b1 || n != expected) begin
            errors++;
            $display("FAIL init_latency2: ready=%b after %0d edges, required 1 after %0d", rdy2, n, expected);
        end
    endtask

    task automatic sweep1();
        we1 = 1'b0;
        for (int a = 0; a < 256; a++) begin
            addr1 = 8'(a);
            #1;
            checks++;
            if (dout1 !== model1[a]) begin
                errors++;
                $display("FAIL sweep1 addr %0d: got %h required %h", a, dout1, model1[a]);
            end
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        rst1 = 1'b0; addr1 = 8'd130;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (rdy1 !== 1'b0 || wd1 !== 1'b0 || dout1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: ready=%b drop=%b dout=%h required 0 0 00", rdy1, wd1, dout1);
        end
        @(negedge Clk); rst1 = 1'b1;
        wait_ready1(268);
        init_model1();
        sweep1();
    endtask

    task automatic test_drop_during_clear();
        @(negedge Clk); rst1 = 1'b0;
        @(negedge Clk); rst1 = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        we1 = 1'b1; addr1 = 8'd7; din1 = 8'hFF;
        @(posedge Clk); #1;
        we1 = 1'b0;
        checks++;
        if (wd1 !== 1'b1) begin
            errors++;
            $display("FAIL drop_clear_pulse: got %b required 1", wd1);
        end
        @(posedge Clk); #1;
        checks++;
        if (wd1 !== 1'b0) begin
            errors++;
            $display("FAIL drop_clear_fall: got %b required 0", wd1);
        end
        wait_ready1(268 - 5);
        init_model1();
        addr1 = 8'd7; #1;
        checks++;
        if (dout1 !== 8'h00) begin
            errors++;
            $display("FAIL drop_clear_addr7: got %h required 00", dout1);
        end
        sweep1();
    endtask

    task automatic test_run_write();
        we1 = 1'b1; addr1 = 8'd5; din1 = 8'hA5;
        #2;
        checks++;
        if (dout1 !== model1[5]) begin
            errors++;
            $display("FAIL rdw_old: got %h required %h", dout1, model1[5]);
        end
        @(posedge Clk); #1;
        we1 = 1'b0; model1[5] = 8'hA5;
        #1;
        checks++;
        if (dout1 !== 8'hA5) begin
            errors++;
            $display("FAIL write_a5: got %h required a5", dout1);
        end
        checks++;
        if (wd1 !== 1'b0) begin
            errors++;
            $display("FAIL write_no_drop: got %b required 0", wd1);
        end
        addr1 = 8'd6; #1;
        checks++;
        if (dout1 !== 8'h00) begin
            errors++;
            $display("FAIL addr6_zero: got %h required 00", dout1);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_random1(input int n);
        logic       w;
        logic [7:0] a, d;
        for (int k = 0; k < n; k++) begin
            w = 1'($urandom_range(0, 1)); a = 8'($urandom_range(0, 255)); d = 8'($urandom);
            we1 = w; addr1 = a; din1 = d;
            #2;
            checks++;
            if (dout1 !== model1[a]) begin
                errors++;
                $display("FAIL rand1_read addr %0d: got %h required %h", a, dout1, model1[a]);
            end
`ifdef DATA_MEM_PARITY_EN
            checks++;
            if (perr1 !== 1'b0) begin
                errors++;
                $display("FAIL rand1_parity: got %b required 0", perr1);
            end
`endif
            @(posedge Clk); #1;
            if (w) model1[a] = d;
            checks++;
            if (wd1 !== 1'b0) begin
                errors++;
                $display("FAIL rand1_drop: got %b required 0", wd1);
            end
        end
        we1 = 1'b0;
    endtask

    task automatic test_reset_mid_preload();
        addr1 = 8'd5; #1;
        rst1 = 1'b0; #1;
        checks++;
        if (rdy1 !== 1'b0 || dout1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: ready=%b dout=%h required 0 00", rdy1, dout1);
        end
        @(negedge Clk); rst1 = 1'b1;
        repeat (261) @(posedge Clk);
        #1;
        checks++;
        if (rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL pre_mid_ready: got %b required 0", rdy1);
        end
        rst1 = 1'b0; #1;
        checks++;
        if (rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_preload_reset: got %b required 0", rdy1);
        end
        @(negedge Clk); rst1 = 1'b1;
        wait_ready1(268);
        init_model1();
        sweep1();
    endtask

    task automatic test_small_no_clear();
        logic       w;
        logic [7:0] a, d;
        logic       exp_drop;
        rst2 = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk); rst2 = 1'b1;
        wait_ready2(12);
        init_model2();
        for (int i = 130; i < 136; i++) begin
            addr2 = 8'(i); #1;
            checks++;
            if (dout2 !== model2[i]) begin
                errors++;
                $display("FAIL small_preload addr %0d: got %h required %h", i, dout2, model2[i]);
            end
        end
        @(posedge Clk); #1;
        we2 = 1'b1; addr2 = 8'd200; din2 = 8'h77;
        @(posedge Clk); #1;
        we2 = 1'b0;
        checks++;
        if (wd2 !== 1'b1) begin
            errors++;
            $display("FAIL small_drop200: got %b required 1", wd2);
        end
        checks++;
        if (dout2 !== 8'h00) begin
            errors++;
            $display("FAIL small_read200: got %h required 00", dout2);
        end
        @(posedge Clk); #1;
        checks++;
        if (wd2 !== 1'b0) begin
            errors++;
            $display("FAIL small_drop_fall: got %b required 0", wd2);
        end
        for (int k = 0; k < 200; k++) begin
            w = 1'($urandom_range(0, 1)); a = 8'($urandom_range(0, 255)); d = 8'($urandom);
            we2 = w; addr2 = a; din2 = d;
            #2;
            if (a >= 136) begin
                checks++;
                if (dout2 !== 8'h00) begin
                    errors++;
                    $display("FAIL rand2_oob addr %0d: got %h required 00", a, dout2);
                end
            end else if (known2[a]) begin
                checks++;
                if (dout2 !== model2[a]) begin
                    errors++;
                    $display("FAIL rand2_read addr %0d: got %h required %h", a, dout2, model2[a]);
                end
            end
            exp_drop = w && (a >= 136);
            @(posedge Clk); #1;
            if (w && a < 136) begin
                model2[a] = d; known2[a] = 1'b1;
            end
            checks++;
            if (wd2 !== exp_drop) begin
                errors++;
                $display("FAIL rand2_drop: got %b required %b", wd2, exp_drop);
            end
        end
        we2 = 1'b0;
    endtask

    task automatic test_retention2();
        we2 = 1'b1; addr2 = 8'd3; din2 = 8'h55;
        @(posedge Clk); #1;
        model2[3] = 8'h55; known2[3] = 1'b1;
        addr2 = 8'd210; din2 = 8'h11;
        @(posedge Clk); #1;
        we2 = 1'b0;
        rst2 = 1'b0; #1;
        checks++;
        if (wd2 !== 1'b0 || rdy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset2_async: drop=%b ready=%b required 0 0", wd2, rdy2);
        end
        @(negedge Clk); rst2 = 1'b1;
        wait_ready2(12);
        init_model2();
        addr2 = 8'd3; #1;
        checks++;
        if (dout2 !== 8'h55) begin
            errors++;
            $display("FAIL retention addr3: got %h required 55", dout2);
        end
        @(posedge Clk); #1;
    endtask

`ifdef DATA_MEM_PARITY_EN
    task automatic test_parity();
        we1 = 1'b1; addr1 = 8'd9; din1 = 8'h3C;
        @(posedge Clk); #1;
        we1 = 1'b0; model1[9] = 8'h3C;
        #1;
        checks++;
        if (perr1 !== 1'b0) begin
            errors++;
            $display("FAIL parity_clean: got %b required 0", perr1);
        end
        u_dut.r_mem[9][0] = ~u_dut.r_mem[9][0];
        #1;
        checks++;
        if (perr1 !== 1'b1) begin
            errors++;
            $display("FAIL parity_flip: got %b required 1", perr1);
        end
        addr1 = 8'd10; #1;
        checks++;
        if (perr1 !== 1'b0) begin
            errors++;
            $display("FAIL parity_addr10: got %b required 0", perr1);
        end
        u_dut.r_mem[9][0] = ~u_dut.r_mem[9][0];
        @(posedge Clk); #1;
    endtask
`endif

    initial begin
        rst1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
        rst2 = 1'b0; we2 = 1'b0; addr2 = '0; din2 = '0;
        for (int a = 0; a < 256; a++) begin
            model2[a] = 8'h00; known2[a] = 1'b0;
        end
        test_reset();
        test_run_write();
        test_random1(300);
        test_drop_during_clear();
        test_reset_mid_preload();
        test_random1(100);
`ifdef DATA_MEM_PARITY_EN
        test_parity();
`endif
        test_small_no_clear();
        test_retention2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
